// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared line/index constants, dispatch state enum, index-to-one-hot helper
package enc_pkg;

  localparam int LINE_N = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dispatch_state_t;

  function automatic logic [LINE_N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    idx_to_onehot      = '0;
    idx_to_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/idx_fifo.sv
// rtl/idx_fifo.sv - synchronous show-ahead FIFO of line indices with count/full/empty
module idx_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Full blocks writes even when a read frees a slot in the same cycle.
  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/onehot_dispatch_3to8.sv
// rtl/onehot_dispatch_3to8.sv - queued 3-bit index to one-hot request dispatcher; optional DISPATCH_TIMEOUT_EN
module onehot_dispatch_3to8
  import enc_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  in_code,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LINE_N-1:0] out_onehot,
  output logic              out_valid,
  input  logic [LINE_N-1:0] ack,
  output logic              stray_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  dispatch_cnt,
  output logic              timeout_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  dispatch_state_t   r_state;
  dispatch_state_t   w_next;
  logic [LINE_N-1:0] r_onehot;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_done;
  logic              w_hit;
  logic              w_tmo;

  idx_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (in_valid),
    .i_wr_data (in_code),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_hit = |(ack & r_onehot);

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  // Fires on the TIMEOUT_CYC-th DRIVE cycle; a same-cycle ack takes priority.
  assign w_tmo = (r_state == DRIVE) && !w_hit && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_err <= w_tmo;
      if (w_pop)                  r_tmo_cnt <= '0;
      else if (r_state == DRIVE)  r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign timeout_err = r_tmo_err;
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = DRIVE;
        end
      end
      DRIVE: begin
        if (w_hit) begin
          w_done = 1'b1;
          w_next = GAP;
        end else if (w_tmo) begin
          w_next = GAP;
        end
      end
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_onehot <= '0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_pop) begin
        r_onehot <= idx_to_onehot(w_head);
        r_valid  <= 1'b1;
      end else if ((r_state == DRIVE) && (w_hit || w_tmo)) begin
        r_onehot <= '0;
        r_valid  <= 1'b0;
      end
      if (w_done) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready     = !w_full;
  assign out_onehot   = r_onehot;
  assign out_valid    = r_valid;
  assign dispatch_cnt = r_cnt;
  assign stray_ack    = |(ack & ~r_onehot);
  assign busy         = (w_count != '0) || (r_state != IDLE);

endmodule
